// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO stream reader.
// Skid pointer/occupancy types and the beat-counter width helper.
package fifo_pkg;

    typedef logic       skid_ptr_t;
    typedef logic [1:0] skid_cnt_t;

    localparam int SKID_DEPTH = 2;

    function automatic int beat_width(input int pkt_len);
        return $clog2(pkt_len + 1);
    endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry circular skid buffer.
// Registered head word and occupancy; clear empties it in one cycle.
module stream_skid_buffer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head,
    output skid_cnt_t             o_count
);

    localparam skid_cnt_t FULL = skid_cnt_t'(SKID_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [SKID_DEPTH];
    skid_ptr_t             r_wptr;
    skid_ptr_t             r_rptr;
    skid_cnt_t             r_count;

    // Pointer and occupancy bookkeeping; push and pop together keep count.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= ~r_wptr;
            if (i_pop)  r_rptr <= ~r_rptr;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Data storage needs no reset; occupancy qualifies it.
    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wptr] <= i_din;
    end

    // The credit scheme upstream must never overfill the buffer.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_clear) begin
            assert (!(i_push && !i_pop && r_count == FULL));
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO pop-side to ready/valid stream adapter.
// Credit-based read issue, in-flight tracking, packet counter, error flag.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int PKT_LEN      = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            fifo_empty,
    output logic                            fifo_shift_out,
    input  logic [DATA_WIDTH-1:0]           fifo_dout,
    input  logic                            fifo_valid,
    output logic [DATA_WIDTH-1:0]           m_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic                            m_last,
    input  logic                            flush,
    output logic [beat_width(PKT_LEN)-1:0]  beat_count,
    output logic                            err_unexpected
);

    localparam int             BW        = beat_width(PKT_LEN);
    localparam logic [BW-1:0]  LAST_BEAT = BW'(PKT_LEN - 1);

    skid_cnt_t     w_occ;
    logic          w_pop;
    logic          w_push;
    logic          w_inflight;
    logic          w_expected;
    logic          w_unexpected;
    logic [2:0]    w_used;
    logic [2:0]    w_limit;
    logic          r_discard;
    logic          r_err;
    logic [BW-1:0] r_beat;

    assign m_valid = (w_occ != '0) && !flush && !rst;
    assign w_pop   = m_valid && m_ready;

    // Words held plus words requested must stay within the skid depth.
    assign w_used  = {1'b0, w_occ} + {2'b00, w_inflight};
    assign w_limit = 3'd2 + {2'b00, w_pop};

    assign fifo_shift_out = !fifo_empty && !flush && !rst && (w_used < w_limit);

    generate
        if (READ_LATENCY == 0) begin : g_rl0
            assign w_inflight = 1'b0;
            assign w_expected = fifo_shift_out;
        end else begin : g_rl1
            logic r_inflight;
            // One outstanding read at most; it returns the cycle after issue.
            always_ff @(posedge clk) begin
                if (rst) r_inflight <= 1'b0;
                else     r_inflight <= fifo_shift_out;
            end
            assign w_inflight = r_inflight;
            assign w_expected = r_inflight;
        end
    endgenerate

    assign w_push       = fifo_valid && w_expected && !flush;
    assign w_unexpected = fifo_valid && !w_expected && !flush && !r_discard;

    // Late returns right after a flush or reset are dropped silently.
    always_ff @(posedge clk) begin
        if (rst) r_discard <= 1'b1;
        else     r_discard <= flush;
    end

    // Sticky error for data that nobody asked for.
    always_ff @(posedge clk) begin
        if (rst)               r_err <= 1'b0;
        else if (w_unexpected) r_err <= 1'b1;
    end

    // Beat index within the packet, advanced on each transfer.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_beat <= '0;
        end else if (w_pop) begin
            if (r_beat == LAST_BEAT) r_beat <= '0;
            else                     r_beat <= r_beat + 1'b1;
        end
    end

    stream_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_clear (flush),
        .i_push  (w_push),
        .i_din   (fifo_dout),
        .i_pop   (w_pop),
        .o_head  (m_data),
        .o_count (w_occ)
    );

    assign m_last         = m_valid && (r_beat == LAST_BEAT);
    assign beat_count     = r_beat;
    assign err_unexpected = r_err;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader.
// Two instances: read latency 1 / 16-beat packets, and latency 0 / 1-beat packets.
module tb_fifo_stream_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---- latency-1 instance and its FIFO model ----
    logic        fe1, so1, fv1, mv1, mr1, ml1, fl1, err1;
    logic        inj1 = 1'b0;
    logic [31:0] dout1, md1;
    logic [4:0]  bc1;
    logic [31:0] mem1 [0:127];
    int          wr1 = 0;
    int          rd1 = 0;
    logic        r_fv1 = 1'b0;
    logic [31:0] r_do1 = '0;

    assign fe1   = (wr1 == rd1);
    assign fv1   = r_fv1 | inj1;
    assign dout1 = inj1 ? 32'hDEAD_BEEF : r_do1;

    always @(posedge clk) begin
        r_fv1 <= 1'b0;
        if (so1 && wr1 != rd1) begin
            r_do1 <= mem1[rd1];
            r_fv1 <= 1'b1;
            rd1   <= rd1 + 1;
        end
    end

    fifo_stream_reader #(
        .DATA_WIDTH   (32),
        .READ_LATENCY (1),
        .PKT_LEN      (16)
    ) dut1 (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty     (fe1),
        .fifo_shift_out (so1),
        .fifo_dout      (dout1),
        .fifo_valid     (fv1),
        .m_data         (md1),
        .m_valid        (mv1),
        .m_ready        (mr1),
        .m_last         (ml1),
        .flush          (fl1),
        .beat_count     (bc1),
        .err_unexpected (err1)
    );

    // ---- latency-0 instance and its FIFO model ----
    logic        fe0, so0, fv0, mv0, mr0, ml0, fl0, err0;
    logic [31:0] dout0, md0;
    logic [0:0]  bc0;
    logic [31:0] mem0 [0:15];
    int          wr0 = 0;
    int          rd0 = 0;

    assign fe0   = (wr0 == rd0);
    assign fv0   = so0 && !fe0;
    assign dout0 = mem0[rd0];

    always @(posedge clk) begin
        if (so0 && wr0 != rd0) rd0 <= rd0 + 1;
    end

    fifo_stream_reader #(
        .DATA_WIDTH   (32),
        .READ_LATENCY (0),
        .PKT_LEN      (1)
    ) dut0 (
        .clk            (clk),
        .rst            (rst),
        .fifo_empty     (fe0),
        .fifo_shift_out (so0),
        .fifo_dout      (dout0),
        .fifo_valid     (fv0),
        .m_data         (md0),
        .m_valid        (mv0),
        .m_ready        (mr0),
        .m_last         (ml0),
        .flush          (fl0),
        .beat_count     (bc0),
        .err_unexpected (err0)
    );

    task automatic push1(input logic [31:0] d);
        mem1[wr1] = d;
        wr1 = wr1 + 1;
    endtask

    task automatic push0(input logic [31:0] d);
        mem0[wr0] = d;
        wr0 = wr0 + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mr1 = 1'b0; fl1 = 1'b0; mr0 = 1'b0; fl0 = 1'b0;
        for (int i = 0; i < 16; i++) push1(32'h10 + i);
        repeat (2) @(negedge clk);
        #1;
        total++; if (so1 !== 1'b0) begin bad++; $display("FAIL rst_shift got %0b want 0", so1); end
        total++; if (mv1 !== 1'b0) begin bad++; $display("FAIL rst_mvalid got %0b want 0", mv1); end
        total++; if (ml1 !== 1'b0) begin bad++; $display("FAIL rst_mlast got %0b want 0", ml1); end
        total++; if (bc1 !== 5'd0) begin bad++; $display("FAIL rst_beat got %0d want 0", bc1); end
        total++; if (err1 !== 1'b0) begin bad++; $display("FAIL rst_err got %0b want 0", err1); end
        total++; if (mv0 !== 1'b0) begin bad++; $display("FAIL rst_mvalid0 got %0b want 0", mv0); end
    endtask

    task automatic test_stream();
        @(negedge clk); rst = 1'b0; mr1 = 1'b1; #1;
        total++; if (so1 !== 1'b1) begin bad++; $display("FAIL s_c0_shift got %0b want 1", so1); end
        total++; if (mv1 !== 1'b0) begin bad++; $display("FAIL s_c0_valid got %0b want 0", mv1); end
        @(negedge clk); #1;
        total++; if (mv1 !== 1'b0) begin bad++; $display("FAIL s_c1_valid got %0b want 0", mv1); end
        total++; if (fv1 !== 1'b1) begin bad++; $display("FAIL s_c1_fvalid got %0b want 1", fv1); end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); #1;
            total++; if (mv1 !== 1'b1) begin bad++; $display("FAIL s_valid beat %0d got %0b want 1", i, mv1); end
            total++; if (md1 !== 32'h10 + i) begin bad++; $display("FAIL s_data beat %0d got %0h want %0h", i, md1, 32'h10 + i); end
            total++; if (bc1 !== 5'(i)) begin bad++; $display("FAIL s_beat beat %0d got %0d want %0d", i, bc1, i); end
            total++; if (ml1 !== (i == 15)) begin bad++; $display("FAIL s_last beat %0d got %0b want %0b", i, ml1, (i == 15)); end
        end
        @(negedge clk); #1;
        total++; if (mv1 !== 1'b0) begin bad++; $display("FAIL s_end_valid got %0b want 0", mv1); end
        total++; if (bc1 !== 5'd0) begin bad++; $display("FAIL s_end_beat got %0d want 0", bc1); end
    endtask

    task automatic test_backpressure();
        int   issued = 0;
        int   xfer = 0;
        int   got = 0;
        logic held = 1'b0;
        logic full_seen = 1'b0;
        logic exp_so;
        logic [31:0] held_d = '0;
        for (int k = 0; k < 120 && got < 16; k++) begin
            @(negedge clk);
            if (k == 0) for (int i = 0; i < 16; i++) push1(32'h10 + i);
            mr1 = (k % 4 == 0) || (k % 4 == 3);
            #1;
            if (issued - xfer == 2) full_seen = 1'b1;
            exp_so = !fe1 && ((issued - xfer - int'(mv1 && mr1)) < 2);
            total++; if (so1 !== exp_so) begin bad++; $display("FAIL bp_credit cycle %0d got %0b want %0b", k, so1, exp_so); end
            if (held) begin
                total++; if (mv1 !== 1'b1 || md1 !== held_d) begin bad++; $display("FAIL bp_hold cycle %0d got %0b/%0h want 1/%0h", k, mv1, md1, held_d); end
            end
            if (mv1 && mr1) begin
                total++; if (md1 !== 32'h10 + got) begin bad++; $display("FAIL bp_order got %0h want %0h", md1, 32'h10 + got); end
                got++;
            end
            held   = mv1 && !mr1;
            held_d = md1;
            if (so1) issued++;
            if (mv1 && mr1) xfer++;
        end
        total++; if (got != 16) begin bad++; $display("FAIL bp_count got %0d want 16", got); end
        total++; if (full_seen !== 1'b1) begin bad++; $display("FAIL bp_full got %0b want 1", full_seen); end
        @(negedge clk); mr1 = 1'b1; #1;
        total++; if (mv1 !== 1'b0) begin bad++; $display("FAIL bp_nodup got %0b want 0", mv1); end
        total++; if (bc1 !== 5'd0) begin bad++; $display("FAIL bp_beat got %0d want 0", bc1); end
    endtask

    task automatic test_gap();
        logic [31:0] exp_d [4];
        int got = 0;
        exp_d[0] = 32'hA; exp_d[1] = 32'hB; exp_d[2] = 32'hC; exp_d[3] = 32'hD;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (c == 0) begin push1(32'hA); push1(32'hB); push1(32'hC); end
            if (c == 9) push1(32'hD);
            #1;
            if (c >= 5 && c <= 10) begin
                total++; if (mv1 !== 1'b0) begin bad++; $display("FAIL gap_idle cycle %0d got %0b want 0", c, mv1); end
            end
            if (mv1 && got < 4) begin
                total++; if (md1 !== exp_d[got]) begin bad++; $display("FAIL gap_data got %0h want %0h", md1, exp_d[got]); end
                total++; if (bc1 !== 5'(got)) begin bad++; $display("FAIL gap_beat got %0d want %0d", bc1, got); end
                got++;
            end
        end
        total++; if (got != 4) begin bad++; $display("FAIL gap_count got %0d want 4", got); end
        total++; if (bc1 !== 5'd4) begin bad++; $display("FAIL gap_endbeat got %0d want 4", bc1); end
    endtask

    task automatic test_flush();
        @(negedge clk); mr1 = 1'b0;
        for (int i = 0; i < 4; i++) push1(32'h50 + i);
        #1;
        total++; if (so1 !== 1'b1) begin bad++; $display("FAIL fl_c0_shift got %0b want 1", so1); end
        @(negedge clk); #1;
        total++; if (so1 !== 1'b1) begin bad++; $display("FAIL fl_c1_shift got %0b want 1", so1); end
        @(negedge clk); fl1 = 1'b1; #1;
        total++; if (mv1 !== 1'b0) begin bad++; $display("FAIL fl_force_valid got %0b want 0", mv1); end
        total++; if (so1 !== 1'b0) begin bad++; $display("FAIL fl_force_shift got %0b want 0", so1); end
        @(negedge clk); fl1 = 1'b0; mr1 = 1'b1; #1;
        total++; if (mv1 !== 1'b0) begin bad++; $display("FAIL fl_after_valid got %0b want 0", mv1); end
        total++; if (bc1 !== 5'd0) begin bad++; $display("FAIL fl_beat got %0d want 0", bc1); end
        @(negedge clk); #1;
        total++; if (mv1 !== 1'b0) begin bad++; $display("FAIL fl_c4_valid got %0b want 0", mv1); end
        @(negedge clk); #1;
        total++; if (mv1 !== 1'b1 || md1 !== 32'h52) begin bad++; $display("FAIL fl_next got %0b/%0h want 1/52", mv1, md1); end
        total++; if (bc1 !== 5'd0) begin bad++; $display("FAIL fl_next_beat got %0d want 0", bc1); end
        @(negedge clk); #1;
        total++; if (mv1 !== 1'b1 || md1 !== 32'h53) begin bad++; $display("FAIL fl_next2 got %0b/%0h want 1/53", mv1, md1); end
        total++; if (bc1 !== 5'd1) begin bad++; $display("FAIL fl_next2_beat got %0d want 1", bc1); end
        @(negedge clk); #1;
        total++; if (err1 !== 1'b0) begin bad++; $display("FAIL fl_err got %0b want 0", err1); end
        total++; if (mv1 !== 1'b0) begin bad++; $display("FAIL fl_drained got %0b want 0", mv1); end
    endtask

    task automatic test_error();
        int got = 0;
        @(negedge clk); inj1 = 1'b1; #1;
        total++; if (err1 !== 1'b0) begin bad++; $display("FAIL err_pre got %0b want 0", err1); end
        @(negedge clk); inj1 = 1'b0; #1;
        total++; if (err1 !== 1'b1) begin bad++; $display("FAIL err_set got %0b want 1", err1); end
        total++; if (mv1 !== 1'b0) begin bad++; $display("FAIL err_drop got %0b want 0", mv1); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) begin push1(32'h60); push1(32'h61); end
            #1;
            total++; if (err1 !== 1'b1) begin bad++; $display("FAIL err_sticky cycle %0d got %0b want 1", c, err1); end
            if (mv1 && got < 2) begin
                total++; if (md1 !== 32'h60 + got) begin bad++; $display("FAIL err_data got %0h want %0h", md1, 32'h60 + got); end
                got++;
            end
        end
        total++; if (got != 2) begin bad++; $display("FAIL err_count got %0d want 2", got); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        total++; if (err1 !== 1'b0) begin bad++; $display("FAIL err_clear got %0b want 0", err1); end
        total++; if (bc1 !== 5'd0) begin bad++; $display("FAIL err_rst_beat got %0d want 0", bc1); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_rl0();
        @(negedge clk); mr0 = 1'b1;
        for (int i = 0; i < 4; i++) push0(32'h30 + i);
        #1;
        total++; if (mv0 !== 1'b0) begin bad++; $display("FAIL r0_c0_valid got %0b want 0", mv0); end
        total++; if (so0 !== 1'b1) begin bad++; $display("FAIL r0_c0_shift got %0b want 1", so0); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            total++; if (mv0 !== 1'b1 || md0 !== 32'h30 + i) begin bad++; $display("FAIL r0_beat %0d got %0b/%0h want 1/%0h", i, mv0, md0, 32'h30 + i); end
            total++; if (ml0 !== 1'b1) begin bad++; $display("FAIL r0_last %0d got %0b want 1", i, ml0); end
            total++; if (bc0 !== 1'b0) begin bad++; $display("FAIL r0_count %0d got %0d want 0", i, bc0); end
        end
        @(negedge clk); #1;
        total++; if (mv0 !== 1'b0) begin bad++; $display("FAIL r0_end got %0b want 0", mv0); end
        total++; if (err0 !== 1'b0) begin bad++; $display("FAIL r0_err got %0b want 0", err0); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_gap();
        test_flush();
        test_error();
        test_rl0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
- Consumer-side adapter for the team's basic synchronous FIFO pop interface (shift_out / dout / valid / empty).
- Drains the FIFO and presents the data as a ready/valid master stream with full throughput and backpressure.
- Generates a packet-boundary flag on every PKT_LEN-th beat.
- Sits between any FIFO instance and downstream stream consumers, so each consumer does not re-implement read-latency handling.

Parameters:
- DATA_WIDTH, 32, width of the FIFO word and of m_data.
- READ_LATENCY, 1, latency of the attached FIFO. 0 means the word is valid in the same cycle as shift_out; 1 means one cycle later. Only values 0 and 1 are legal.
- PKT_LEN, 16, beats per packet; m_last marks the final beat. Must be ≥1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_shift_out  out  1  pop request to the FIFO.
- fifo_dout  in  DATA_WIDTH  FIFO read data.
- fifo_valid  in  1  FIFO read-data valid.
- m_data  out  DATA_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  last beat of a packet.
- flush  in  1  discard buffered and in-flight data; restart packet count.
- beat_count  out  $clog2(PKT_LEN+1)  index of the current head beat within its packet.
- err_unexpected  out  1  sticky; set when fifo_valid arrives with no read outstanding.

Behaviour:
- Reset (rst=1 at an edge): skid occupancy 0, in-flight count 0, beat_count 0, err_unexpected 0. Outputs during reset: m_valid 0, m_last 0, fifo_shift_out 0. m_data is don't-care.
- Storage is a 2-entry skid buffer: circular, 1-bit read and write pointers, 2-bit occupancy.
- m_valid = occupancy≠0. m_data is the head entry. m_valid and m_data are registered state, never combinational from fifo_dout.
- Transfer happens when m_valid && m_ready. Once m_valid is high, m_data must stay stable until a transfer occurs; flush and rst are the only exceptions.
- Credit rule: pop_now = m_valid && m_ready. fifo_shift_out = !fifo_empty && !flush && (occupancy + in_flight − pop_now) < 2.
- In-flight count:
  - READ_LATENCY=0: none. Data is captured in the same cycle as shift_out, when fifo_valid=1.
  - READ_LATENCY=1: a 1-bit in-flight register, set to the issued shift_out. Data is written when fifo_valid=1 on the next cycle.
- Latency, READ_LATENCY=1: FIFO non-empty at cycle N gives shift_out at N, fifo_valid at N+1, and m_valid at N+2.
- Latency, READ_LATENCY=0: m_valid at N+1.
- Throughput: one beat per cycle sustained while the FIFO is non-empty and m_ready is held high.
- Simultaneous write and pop: occupancy is unchanged and both pointers advance.
- A write arriving when occupancy=2 cannot occur under the credit rule. It must be asserted in simulation.
- fifo_valid=1 with no read outstanding:
  - READ_LATENCY=1: in-flight was 0 on the previous cycle.
  - READ_LATENCY=0: shift_out=0 this cycle.
  - Effect: data is dropped and err_unexpected is set; it clears only on rst.
- Packet counter: beat_count increments on each transfer and wraps to 0 after PKT_LEN−1. m_last = m_valid && beat_count==PKT_LEN−1.
- flush:
  - Occupancy → 0 next cycle; beat_count → 0; shift_out is forced 0 during flush.
  - An in-flight word that returns in the flush cycle or the cycle after is discarded, tracked by a 1-bit discard flag. It does not set err_unexpected.
  - A transfer in the flush cycle is not performed: m_valid is forced 0 while flush=1.
- Reset mid-packet behaves identically to flush, plus it clears err_unexpected.
- FIFO wrap-around and full conditions are invisible to this block; only empty and valid matter.

Decomposition:
- Shared package fifo_pkg:
  - typedef skid_ptr_t (1 bit) and skid_cnt_t (2 bits).
  - localparam SKID_DEPTH=2.
  - function beat_width(PKT_LEN) returning $clog2(PKT_LEN+1).
- One sub-module, stream_skid_buffer: 2-entry storage with push/pop/clear, head data and occupancy out.
- The top level holds the credit logic, the in-flight/discard tracking, the packet counter and the error flag.

Test Plan:
- FIFO preloaded 0x10..0x1F, READ_LATENCY=1, m_ready held 1 → m_valid first at cycle 2, then 16 consecutive beats 0x10..0x1F, m_last only on 0x1F, beat_count back to 0.
- Same preload, m_ready toggling 1,0,0,1 → no loss or duplication, m_data stable while stalled, fifo_shift_out deasserts once occupancy+in_flight=2.
- FIFO goes empty after 3 words (0xA,0xB,0xC) then refills with 0xD 5 cycles later → m_valid low for the gap, output order 0xA,0xB,0xC,0xD, beat_count continues at 3 for 0xD.
- flush asserted one cycle after shift_out while 1 word is buffered and 1 is in flight → m_valid 0 next cycle, in-flight word discarded, err_unexpected stays 0, next FIFO word delivered with beat_count=0.
- fifo_valid pulsed with no outstanding read → err_unexpected=1 and stays high through later normal traffic until rst, then 0.
- READ_LATENCY=0, PKT_LEN=1, 4 words, m_ready=1 → m_valid at cycle 1, one beat per cycle, m_last high on every beat.
